// File: rtl/timer_unit.sv
// Prescaled up-counter with auto-reload, shadowed PSC/ARR preloads, an overflow pulse and a sticky flag.
// Driven by one-cycle TIMER command strobes from the execute stage.
module timer_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       funct3,
  input  logic             timer_read_reg,
  input  logic [CNT_W-1:0] rs1_data,
  input  logic [CNT_W-1:0] imm,
  output logic [CNT_W-1:0] tim_cnt,
  output logic             tim_running,
  output logic             tim_ovf,
  output logic             tim_flag,
  output logic [CNT_W-1:0] tim_psc,
  output logic [CNT_W-1:0] tim_arr
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] psc_pre_q, psc_pre_d;
  logic [CNT_W-1:0] arr_pre_q, arr_pre_d;
  logic [CNT_W-1:0] psc_act_q, psc_act_d;
  logic [CNT_W-1:0] arr_act_q, arr_act_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] operand;
  logic             cmd_enable, cmd_disable, cmd_wr_psc, cmd_wr_arr, cmd_clrf;
  logic             tick, update;

  assign operand     = timer_read_reg ? rs1_data : imm;
  assign cmd_enable  = cmd_valid && (funct3 == 3'b000);
  assign cmd_disable = cmd_valid && (funct3 == 3'b111);
  assign cmd_wr_psc  = cmd_valid && ((funct3 == 3'b001) || (funct3 == 3'b100));
  assign cmd_wr_arr  = cmd_valid && ((funct3 == 3'b010) || (funct3 == 3'b101));
  assign cmd_clrf    = cmd_valid && (funct3 == 3'b011);

  // ENABLE/DISABLE pre-empt counting, so a coinciding would-be update never fires.
  assign tick   = (state_q == RUN) && !cmd_enable && !cmd_disable && (psc_cnt_q == psc_act_q);
  assign update = tick && (cnt_q == arr_act_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    psc_cnt_d = psc_cnt_q;
    psc_pre_d = psc_pre_q;
    arr_pre_d = arr_pre_q;
    psc_act_d = psc_act_q;
    arr_act_d = arr_act_q;
    flag_d    = flag_q;
    ovf_d     = 1'b0;

    if (cmd_wr_psc) begin
      psc_pre_d = operand;
      if (state_q == IDLE) psc_act_d = operand;
    end
    if (cmd_wr_arr) begin
      arr_pre_d = operand;
      if (state_q == IDLE) arr_act_d = operand;
    end
    if (cmd_clrf) flag_d = 1'b0;

    if (cmd_enable) begin
      state_d   = RUN;
      cnt_d     = '0;
      psc_cnt_d = '0;
      psc_act_d = psc_pre_q;
      arr_act_d = arr_pre_q;
    end else if (cmd_disable) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + CNT_W'(1);
      if (update) begin
        // Shadows take the pre-write preload; a same-cycle write lands next period.
        cnt_d     = '0;
        ovf_d     = 1'b1;
        flag_d    = 1'b1;
        psc_act_d = psc_pre_q;
        arr_act_d = arr_pre_q;
      end else if (tick) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      psc_cnt_q <= '0;
      psc_pre_q <= '0;
      arr_pre_q <= '0;
      psc_act_q <= '0;
      arr_act_q <= '0;
      flag_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psc_cnt_q <= psc_cnt_d;
      psc_pre_q <= psc_pre_d;
      arr_pre_q <= arr_pre_d;
      psc_act_q <= psc_act_d;
      arr_act_q <= arr_act_d;
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tim_cnt     = cnt_q;
  assign tim_running = (state_q == RUN);
  assign tim_ovf     = ovf_q;
  assign tim_flag    = flag_q;
  assign tim_psc     = psc_pre_q;
  assign tim_arr     = arr_pre_q;

endmodule

// File: tb/tb_timer_unit.sv
// Testbench for timer_unit: vector table, directed corner sequences, and
// randomized commands checked against a phase-based period model.
module tb_timer_unit;

  localparam int CNT_W = 32;
  localparam logic [2:0] F_EN = 3'b000, F_PSC = 3'b001, F_ARR = 3'b010, F_CLRF = 3'b011;
  localparam logic [2:0] F_PSC2 = 3'b100, F_ARR2 = 3'b101, F_NOP = 3'b110, F_DIS = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic [2:0]       funct3;
  logic             timer_read_reg;
  logic [CNT_W-1:0] rs1_data;
  logic [CNT_W-1:0] imm;
  logic [CNT_W-1:0] tim_cnt;
  logic             tim_running;
  logic             tim_ovf;
  logic             tim_flag;
  logic [CNT_W-1:0] tim_psc;
  logic [CNT_W-1:0] tim_arr;

  int checks = 0;
  int passes = 0;

  timer_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .funct3(funct3),
    .timer_read_reg(timer_read_reg), .rs1_data(rs1_data), .imm(imm),
    .tim_cnt(tim_cnt), .tim_running(tim_running), .tim_ovf(tim_ovf),
    .tim_flag(tim_flag), .tim_psc(tim_psc), .tim_arr(tim_arr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [2:0]  f3;
    logic        sel;
    logic [31:0] rs1v;
    logic [31:0] immv;
    logic [31:0] e_cnt;
    logic        e_run;
    logic        e_ovf;
    logic        e_flag;
    logic [31:0] e_psc;
    logic [31:0] e_arr;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: position inside the current period rather than separate counters.
  longint      m_phase;
  logic [31:0] m_ppre, m_apre, m_pact, m_aact, m_cnt;
  bit          m_run, m_flag, m_ovf;

  // Drive one cycle of inputs, let one rising edge pass, then settle away from the edge.
  task automatic applyStimulus(input logic rst_n, input logic v, input logic [2:0] f3,
                               input logic sel, input logic [31:0] rs1v, input logic [31:0] immv);
    reset          = rst_n;
    cmd_valid      = v;
    funct3         = f3;
    timer_read_reg = sel;
    rs1_data       = rs1v;
    imm            = immv;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(1'b1, 1'b0, F_NOP, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] e_cnt, input logic e_run,
                             input logic e_ovf, input logic e_flag, input logic [31:0] e_psc,
                             input logic [31:0] e_arr);
    checks++;
    if (tim_cnt === e_cnt && tim_running === e_run && tim_ovf === e_ovf &&
        tim_flag === e_flag && tim_psc === e_psc && tim_arr === e_arr) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got cnt=%0d run=%b ovf=%b flag=%b psc=%0d arr=%0d, want cnt=%0d run=%b ovf=%b flag=%b psc=%0d arr=%0d",
               name, tim_cnt, tim_running, tim_ovf, tim_flag, tim_psc, tim_arr,
               e_cnt, e_run, e_ovf, e_flag, e_psc, e_arr);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, F_NOP, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic addVec(input logic rst_n, input logic v, input logic [2:0] f3, input logic [31:0] immv,
                        input logic [31:0] e_cnt, input logic e_run, input logic e_ovf,
                        input logic e_flag, input logic [31:0] e_psc, input logic [31:0] e_arr);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.f3 = f3; t.sel = 1'b0; t.rs1v = 32'hDEAD_BEEF; t.immv = immv;
    t.e_cnt = e_cnt; t.e_run = e_run; t.e_ovf = e_ovf; t.e_flag = e_flag;
    t.e_psc = e_psc; t.e_arr = e_arr;
    vecs.push_back(t);
  endtask

  task automatic modelStep(input logic rst_n, input logic v, input logic [2:0] f3,
                           input logic sel, input logic [31:0] rs1v, input logic [31:0] immv);
    logic [31:0] op, old_ppre, old_apre;
    bit en, dis, was_run, upd;
    longint per;
    m_ovf = 1'b0;
    if (!rst_n) begin
      m_phase = 0; m_ppre = 0; m_apre = 0; m_pact = 0; m_aact = 0; m_cnt = 0;
      m_run = 0; m_flag = 0;
      return;
    end
    op       = sel ? rs1v : immv;
    en       = v && (f3 == F_EN);
    dis      = v && (f3 == F_DIS);
    old_ppre = m_ppre;
    old_apre = m_apre;
    was_run  = m_run;
    upd      = 1'b0;
    if (en) begin
      m_run = 1; m_phase = 0; m_pact = old_ppre; m_aact = old_apre; m_cnt = 0;
    end else if (dis) begin
      m_run = 0;
    end else if (m_run) begin
      per = (longint'(m_pact) + 1) * (longint'(m_aact) + 1);
      if (m_phase + 1 == per) begin
        upd = 1; m_phase = 0; m_ovf = 1; m_flag = 1; m_pact = old_ppre; m_aact = old_apre;
      end else begin
        m_phase++;
      end
      m_cnt = 32'(m_phase / (longint'(m_pact) + 1));
    end
    if (v && (f3 == F_PSC || f3 == F_PSC2)) begin
      m_ppre = op;
      if (!was_run) m_pact = op;
    end
    if (v && (f3 == F_ARR || f3 == F_ARR2)) begin
      m_apre = op;
      if (!was_run) m_aact = op;
    end
    if (v && f3 == F_CLRF && !upd) m_flag = 0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; funct3 = F_NOP; timer_read_reg = 1'b0;
    rs1_data = '0; imm = '0;

    // psc=0, arr=2: wrap every 3 cycles, CLRF alone clears, CLRF with update keeps flag set.
    addVec(0, 0, F_NOP,  0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, F_PSC,  0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, F_ARR,  2, 0, 0, 0, 0, 0, 2);
    addVec(1, 1, F_EN,   0, 0, 1, 0, 0, 0, 2);
    addVec(1, 0, F_NOP,  0, 1, 1, 0, 0, 0, 2);
    addVec(1, 0, F_NOP,  0, 2, 1, 0, 0, 0, 2);
    addVec(1, 0, F_NOP,  0, 0, 1, 1, 1, 0, 2);
    addVec(1, 0, F_NOP,  0, 1, 1, 0, 1, 0, 2);
    addVec(1, 1, F_CLRF, 0, 2, 1, 0, 0, 0, 2);
    addVec(1, 0, F_NOP,  0, 0, 1, 1, 1, 0, 2);
    addVec(1, 0, F_NOP,  0, 1, 1, 0, 1, 0, 2);
    addVec(1, 0, F_NOP,  0, 2, 1, 0, 1, 0, 2);
    addVec(1, 1, F_CLRF, 0, 0, 1, 1, 1, 0, 2);
    addVec(1, 1, F_NOP,  9, 1, 1, 0, 1, 0, 2);
    addVec(1, 1, F_DIS,  0, 1, 0, 0, 1, 0, 2);
    addVec(1, 0, F_NOP,  0, 1, 0, 0, 1, 0, 2);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].v, vecs[i].f3, vecs[i].sel, vecs[i].rs1v, vecs[i].immv);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_run, vecs[i].e_ovf,
                  vecs[i].e_flag, vecs[i].e_psc, vecs[i].e_arr);
    end

    // Reset mid-RUN with psc=3, arr=5 at cnt=2.
    doReset();
    applyStimulus(1, 1, F_PSC, 0, 0, 3);
    applyStimulus(1, 1, F_ARR, 0, 0, 5);
    applyStimulus(1, 1, F_EN,  0, 0, 0);
    for (int k = 1; k <= 8; k++) nop();
    checkOutput("pre_reset", 2, 1, 0, 0, 3, 5);
    doReset();
    checkOutput("mid_reset", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) nop();
    checkOutput("post_reset_idle", 0, 0, 0, 0, 0, 0);

    // psc=1, arr=3 via rs1: each count lasts 2 cycles, period 8.
    doReset();
    applyStimulus(1, 1, F_PSC2, 1, 1, 32'd77);
    applyStimulus(1, 1, F_ARR2, 1, 3, 32'd77);
    applyStimulus(1, 1, F_EN, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      nop();
      checkOutput($sformatf("psc1_k%0d", k), 32'((k / 2) % 4), 1, (k % 8) == 0, k >= 8, 1, 3);
    end

    // ARR 9 -> 2 written at cnt=5: current period still runs to 9.
    doReset();
    applyStimulus(1, 1, F_ARR, 0, 0, 9);
    applyStimulus(1, 1, F_EN,  0, 0, 0);
    for (int k = 0; k < 5; k++) nop();
    applyStimulus(1, 1, F_ARR, 0, 0, 2);
    checkOutput("arr_wr", 6, 1, 0, 0, 0, 2);
    begin
      logic [31:0] exp_cnt[7];
      logic        exp_ovf[7];
      exp_cnt = '{7, 8, 9, 0, 1, 2, 0};
      exp_ovf = '{0, 0, 0, 1, 0, 0, 1};
      for (int k = 0; k < 7; k++) begin
        nop();
        checkOutput($sformatf("arr_chg%0d", k), exp_cnt[k], 1, exp_ovf[k], k >= 3, 0, 2);
      end
    end

    // DISABLE at cnt=4 freezes the count; ENABLE restarts from 0 with current preloads.
    doReset();
    applyStimulus(1, 1, F_ARR, 0, 0, 9);
    applyStimulus(1, 1, F_EN,  0, 0, 0);
    for (int k = 0; k < 4; k++) nop();
    applyStimulus(1, 1, F_DIS, 0, 0, 0);
    checkOutput("dis_edge", 4, 0, 0, 0, 0, 9);
    for (int k = 0; k < 12; k++) nop();
    checkOutput("dis_frozen", 4, 0, 0, 0, 0, 9);
    applyStimulus(1, 1, F_ARR, 0, 0, 1);
    applyStimulus(1, 1, F_EN,  0, 0, 0);
    checkOutput("reen", 0, 1, 0, 0, 0, 1);
    nop();
    checkOutput("reen1", 1, 1, 0, 0, 0, 1);
    nop();
    checkOutput("reen2", 0, 1, 1, 1, 0, 1);

    // ARR write 4 -> 7 on the wrap edge: next period uses 4, the one after uses 7.
    doReset();
    applyStimulus(1, 1, F_ARR, 0, 0, 4);
    applyStimulus(1, 1, F_EN,  0, 0, 0);
    for (int k = 0; k < 4; k++) nop();
    applyStimulus(1, 1, F_ARR, 0, 0, 7);
    checkOutput("wrap_wr", 0, 1, 1, 1, 0, 7);
    for (int k = 1; k <= 5; k++) begin
      nop();
      checkOutput($sformatf("per4_%0d", k), 32'(k % 5), 1, k == 5, 1, 0, 7);
    end
    for (int k = 1; k <= 8; k++) begin
      nop();
      checkOutput($sformatf("per7_%0d", k), 32'(k % 8), 1, k == 8, 1, 0, 7);
    end

    // Randomized commands against the period model.
    doReset();
    modelStep(0, 0, F_NOP, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      logic        r_rst, r_v, r_sel;
      logic [2:0]  r_f3;
      logic [31:0] r_rs1, r_imm;
      r_rst = ($urandom_range(0, 199) != 0);
      r_v   = ($urandom_range(0, 9) < 3);
      r_f3  = 3'($urandom_range(0, 7));
      if (r_f3 == F_EN && $urandom_range(0, 1) == 1) r_f3 = F_NOP;
      r_sel = 1'($urandom_range(0, 1));
      r_rs1 = 32'($urandom_range(0, 3));
      r_imm = 32'($urandom_range(0, 3));
      applyStimulus(r_rst, r_v, r_f3, r_sel, r_rs1, r_imm);
      modelStep(r_rst, r_v, r_f3, r_sel, r_rs1, r_imm);
      checkOutput($sformatf("rand%0d", n), m_cnt, m_run, m_ovf, m_flag, m_ppre, m_apre);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/timer_unit.md
# timer_unit

Memory-less general-purpose timer peripheral that executes the custom TIMER instructions (opcode 0100101) decoded by the control unit. It sits in the execute stage, downstream of the control unit and register file. It consumes a one-cycle command strobe, funct3, the operand-source select `timer_read_reg`, rs1 data and the sign-extended immediate. It provides a prescaled 32-bit up-counter with auto-reload, shadowed PSC/ARR, an overflow pulse and a sticky overflow flag.

## Interface
Parameters:
- CNT_W, 32, width of counter, prescaler and auto-reload registers (32 is the only verified value)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  one-cycle strobe: a TIMER instruction is in execute this cycle
- funct3  in  3  TIMER sub-op: 000 ENABLE, 111 DISABLE, 001/100 write PSC, 010/101 write ARR, 011 CLRF (clear flag), 110 ignored
- timer_read_reg  in  1  operand source for PSC/ARR writes: 1 = rs1_data, 0 = imm
- rs1_data  in  CNT_W  register operand
- imm  in  CNT_W  immediate operand
- tim_cnt  out  CNT_W  current counter value
- tim_running  out  1  1 in RUN state
- tim_ovf  out  1  one-cycle pulse on update event
- tim_flag  out  1  sticky overflow flag
- tim_psc  out  CNT_W  PSC preload register
- tim_arr  out  CNT_W  ARR preload register

## Operation
- Registers: psc_pre, arr_pre (software-visible preload); psc_act, arr_act (active shadows); psc_cnt; cnt; flag; state.
- States: IDLE (reset state), RUN.
- Commands act only when cmd_valid=1; funct3=110, or cmd_valid=0, is a no-op.
- Operand = timer_read_reg ? rs1_data : imm.
- PSC write: psc_pre <= operand. ARR write: arr_pre <= operand. In IDLE the same operand is also written to psc_act/arr_act. In RUN the active copy is updated only at the next update event.
- ENABLE (any state): state <= RUN; cnt <= 0; psc_cnt <= 0; psc_act <= psc_pre; arr_act <= arr_pre. ENABLE in RUN is a restart.
- DISABLE: state <= IDLE; cnt and psc_cnt freeze at current values; flag unchanged.
- CLRF: flag <= 0.
- RUN, every cycle with no ENABLE/DISABLE:
  - If psc_cnt == psc_act: psc_cnt <= 0 and a tick occurs. Otherwise psc_cnt <= psc_cnt+1.
  - On a tick: if cnt == arr_act, an update event occurs: cnt <= 0; tim_ovf=1 next cycle; flag <= 1; psc_act <= psc_pre; arr_act <= arr_pre. Otherwise cnt <= cnt+1.
- Period = (psc_act+1)*(arr_act+1) cycles. psc=0 means a tick every cycle. arr=0 means an update every tick.
- Counters compare by equality only and never exceed their active limit. A new ARR below the current cnt cannot take effect mid-period because arr_act changes only at update.
- Simultaneous events:
  - PSC/ARR write in the same cycle as an update: the shadows load the pre-write preload value. The new value applies at the following update.
  - CLRF with an update: set wins, flag=1.
  - DISABLE with a would-be update: DISABLE wins; no pulse, flag and shadows unchanged, cnt frozen at the pre-edge value.
  - ENABLE with a would-be update: restart wins; no pulse.
- Reset (reset=0 at an edge, any state, including mid-count): state IDLE; all registers 0. Outputs after the edge: tim_cnt=0, tim_running=0, tim_ovf=0, tim_flag=0, tim_psc=0, tim_arr=0.

## Timing
- All outputs are registered. The effect of a command sampled at edge N is visible after edge N.
- ENABLE at edge N: tim_running=1 and cnt=0 after N. The first psc_cnt compare happens at edge N+1.
- Example, psc=0, arr=2, ENABLE at N: cnt = 1,2,0 after edges N+1, N+2, N+3. tim_ovf=1 only in the cycle after N+3. The flag is 1 from then on.
- Update latency: tim_ovf asserts in the same cycle that cnt shows 0 after wrap.
- tim_ovf is never high for two consecutive cycles unless psc_act=0 and arr_act=0. In that case it is high every cycle while in RUN.
- No backpressure: a command is accepted in every cycle it is presented.

## Test plan
- Reset mid-RUN (psc=3, arr=5, cnt=2): drive reset=0 one edge -> all outputs 0, IDLE. Counting does not resume until ENABLE.
- psc=0 (imm), arr=2 (imm), ENABLE -> tim_ovf pulses every 3 cycles, first in the cycle after edge N+3. tim_flag set. CLRF clears it. CLRF coinciding with an update leaves flag=1.
- psc=1 via rs1_data=1 (timer_read_reg=1), arr=3 -> update period 8 cycles. cnt holds each value for 2 cycles.
- In RUN with arr=9, write ARR=2 at cnt=5 -> cnt continues to 9. The update occurs, after which the period is 3 ticks. tim_arr reads 2 immediately after the write.
- DISABLE at cnt=4 -> cnt frozen at 4, tim_running=0, no tim_ovf. ENABLE afterward -> cnt restarts from 0 using the current preloads.
- ARR write coinciding with an update (arr_pre=4 -> 7 at the wrap edge) -> the next period uses 4. The period after that uses 7.
